// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Imported by the datapath top so the state encoding lives in one place.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: difference and borrow of x - y - bi.
// Purely combinational; the serial datapath reuses one instance every bit.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b - bin LSB-first through one cell.
// Input handshake: a transfer happens on a rising edge where in_valid, in_ready and ena are all high; the output transfer likewise needs out_valid, out_ready and ena.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             br;
    logic [CW-1:0]    count;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] diff_next;

    full_subtractor_cell u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign diff_next = {cell_d, diff_sr[WIDTH-1:1]};
    assign in_ready  = (state == IDLE) && !rst;

    // diff/bout are separate from the working shift register so the result
    // ports hold the previous answer while the next operation is shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            diff_sr   <= '0;
            br        <= 1'b0;
            count     <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= diff_next;
                    br      <= cell_bo;
                    if (count == LAST) begin
                        diff      <= diff_next;
                        bout      <= cell_bo;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
